bp_resolve_ctrl: RTL

//  Sequences the branch predictor. Carries the IF prediction (pTaken/pTarget) down IF->ID->EX and

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_resolve_ctrl_fifo.sv | 48 ++++
 rtl/bp_resolve_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor resolve controller: branch classes,
// per-stage prediction metadata, update records and the controller states.
package bp_pkg;

  typedef enum logic [1:0] {
    BT_OTHER = 2'b00,
    BT_JAL   = 2'b01,
    BT_BR    = 2'b10
  } btype_e;

  typedef struct packed {
    logic        valid;
    logic        ptaken;
    logic [31:0] ptarget;
  } bp_meta_t;

  typedef struct packed {
    logic [31:0] pc;
    btype_e      btype;
    logic        taken;
    logic [31:0] target;
  } bp_upd_t;

  typedef enum logic {
    RUN   = 1'b0,
    INVAL = 1'b1
  } state_e;

endpackage

// File: rtl/bp_resolve_ctrl_fifo.sv
// Synchronous FIFO of predictor update records; extra pointer bit separates full from empty.
// A pop in the same cycle frees a slot for a push into a full FIFO.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int UPD_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  logic    push,
  input  bp_upd_t wdata,
  input  logic    pop,
  output bp_upd_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(UPD_DEPTH);

  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;
  bp_upd_t     mem [UPD_DEPTH];

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bp_resolve_ctrl.sv
// Branch prediction resolve/redirect controller with update queue and BTB/PHT invalidate walk.
// Optional performance counters are built when BP_PERF_CNT_EN is defined.
module bp_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int UPD_DEPTH  = 4,
  parameter int BP_ENTRIES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_adv,
  input  logic                          irq,
  input  logic                          if_valid,
  input  logic                          if_ptaken,
  input  logic [31:0]                   if_ptarget,
  input  logic [31:0]                   ex_pc,
  input  logic [1:0]                    ex_btype,
  input  logic                          ex_rtaken,
  input  logic [31:0]                   ex_btarget,
  output logic                          redirect,
  output logic [31:0]                   redirect_pc,
  output logic                          pred_en,
  output logic                          upd_valid,
  input  logic                          upd_ready,
  output logic [31:0]                   upd_pc,
  output logic [1:0]                    upd_btype,
  output logic                          upd_taken,
  output logic [31:0]                   upd_target,
  output logic                          inval,
  output logic [$clog2(BP_ENTRIES)-1:0] inval_idx
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_br,
  output logic [31:0]                   perf_misp,
  output logic [15:0]                   perf_drop
`endif
);

  localparam int IDX_W = $clog2(BP_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BP_ENTRIES - 1);

  state_e      state, state_nxt;
  bp_meta_t    id_meta_p1, ex_meta_p2;
  bp_upd_t     upd_in, upd_head;
  logic [31:0] pc_inc, pnext, anext;
  logic        is_br, run_ok, misp, push_req;
  logic        fifo_full, fifo_empty, fifo_pop, walk_last;

  // EX stage: compare the carried prediction against the resolution
  assign pc_inc   = ex_pc + 32'd4;
  assign is_br    = (btype_e'(ex_btype) != BT_OTHER);
  assign pnext    = (ex_meta_p2.valid && ex_meta_p2.ptaken) ? ex_meta_p2.ptarget : pc_inc;
  assign anext    = (is_br && ex_rtaken) ? ex_btarget : pc_inc;
  assign run_ok   = (state == RUN) && !irq && pipe_adv && ex_meta_p2.valid;
  assign misp     = run_ok && (pnext != anext);
  assign push_req = run_ok && is_br;

  assign redirect    = misp;
  assign redirect_pc = misp ? anext : 32'd0;
  assign walk_last   = (inval_idx == IDX_LAST);

  always_comb begin
    state_nxt = state;
    inval     = 1'b0;
    case (state)
      RUN: begin
        if (irq) state_nxt = INVAL;
      end
      INVAL: begin
        inval = 1'b1;
        if (!irq && walk_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pred_en   <= 1'b0;
      inval_idx <= '0;
    end else begin
      state   <= state_nxt;
      pred_en <= (state_nxt == RUN);
      if (!irq && state == INVAL && !walk_last) inval_idx <= inval_idx + IDX_W'(1);
      else                                      inval_idx <= '0;
    end
  end

  // IF->ID->EX metadata; a redirect or interrupt turns ID/EX into bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_meta_p1 <= '0;
      ex_meta_p2 <= '0;
    end else if (irq || state == INVAL) begin
      id_meta_p1.valid <= 1'b0;
      ex_meta_p2.valid <= 1'b0;
    end else if (pipe_adv) begin
      id_meta_p1 <= '{valid: if_valid, ptaken: if_ptaken, ptarget: if_ptarget};
      ex_meta_p2 <= id_meta_p1;
      if (misp) begin
        id_meta_p1.valid <= 1'b0;
        ex_meta_p2.valid <= 1'b0;
      end
    end
  end

  assign upd_in = '{pc: ex_pc, btype: btype_e'(ex_btype), taken: ex_rtaken, target: ex_btarget};

  bp_upd_fifo #(
    .UPD_DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (irq),
    .push  (push_req),
    .wdata (upd_in),
    .pop   (fifo_pop),
    .rdata (upd_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign upd_valid  = !fifo_empty && (state == RUN);
  assign fifo_pop   = upd_valid && upd_ready;
  assign upd_pc     = upd_valid ? upd_head.pc     : 32'd0;
  assign upd_btype  = upd_valid ? upd_head.btype  : 2'd0;
  assign upd_taken  = upd_valid ? upd_head.taken  : 1'b0;
  assign upd_target = upd_valid ? upd_head.target : 32'd0;

`ifdef BP_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic drop;
  assign drop = push_req && fifo_full && !fifo_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br   <= '0;
      perf_misp <= '0;
      perf_drop <= '0;
    end else begin
      if (push_req) perf_br   <= sat_inc32(perf_br);
      if (misp)     perf_misp <= sat_inc32(perf_misp);
      if (drop)     perf_drop <= sat_inc16(perf_drop);
    end
  end
`endif

endmodule
